// File: rtl/gpio_pkg.sv
// Shared constants and helpers for the GPIO port: register addresses and
// read-data zero extension.
package gpio_pkg;

   localparam int ADDR_W     = 3;
   localparam int MAX_DATA_W = 32;

   localparam logic [ADDR_W-1:0] ADDR_DIR     = 3'd0;
   localparam logic [ADDR_W-1:0] ADDR_OUT     = 3'd1;
   localparam logic [ADDR_W-1:0] ADDR_IN      = 3'd2;
   localparam logic [ADDR_W-1:0] ADDR_IRQ_EN  = 3'd3;
   localparam logic [ADDR_W-1:0] ADDR_RISE_EN = 3'd4;
   localparam logic [ADDR_W-1:0] ADDR_FALL_EN = 3'd5;
   localparam logic [ADDR_W-1:0] ADDR_PEND    = 3'd6;
   localparam logic [ADDR_W-1:0] ADDR_OUT_TGL = 3'd7;

   // Keeps only the low w bits of v; callers cast the result to their bus width.
   function automatic logic [MAX_DATA_W-1:0] zext(input logic [MAX_DATA_W-1:0] v,
                                                  input int unsigned w);
      logic [MAX_DATA_W-1:0] mask;
      mask = {MAX_DATA_W{1'b1}} >> (MAX_DATA_W - w);
      return v & mask;
   endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop input synchroniser for the GPIO pins, cleared by synchronous reset.
module gpio_sync #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [WIDTH-1:0] pad_i,
   output logic [WIDTH-1:0] in_o
);

   logic [WIDTH-1:0] stage_q [SYNC_STAGES];

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            stage_q[s] <= '0;
         end
      end else begin
         stage_q[0] <= pad_i;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            stage_q[s] <= stage_q[s-1];
         end
      end
   end

   assign in_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_port.sv
// Register-controlled bidirectional GPIO port with synchronised inputs and
// sticky, maskable rise/fall edge interrupts.
module gpio_port
   import gpio_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic [ADDR_W-1:0]   addr_in,
   input  logic                wr_en_in,
   input  logic                rd_en_in,
   input  logic [DATA_W-1:0]   wdata_in,
   output logic [DATA_W-1:0]   rdata_out,
   output logic                rvalid_out,
   output logic                irq_out,
   inout  wire  [WIDTH-1:0]    pad_io
);

   logic [WIDTH-1:0]  dir_q, dir_d;
   logic [WIDTH-1:0]  out_q, out_d;
   logic [WIDTH-1:0]  irq_en_q, irq_en_d;
   logic [WIDTH-1:0]  rise_en_q, rise_en_d;
   logic [WIDTH-1:0]  fall_en_q, fall_en_d;
   logic [WIDTH-1:0]  pend_q, pend_d;
   logic [WIDTH-1:0]  prev_q;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rvalid_q;

   logic [WIDTH-1:0]  in_w;
   logic [WIDTH-1:0]  wd;
   logic [WIDTH-1:0]  clr;
   logic [WIDTH-1:0]  set;
   logic [WIDTH-1:0]  rd_val;
   logic [DATA_W-1:0] wdata_unused;

   assign wd           = wdata_in[WIDTH-1:0];
   assign wdata_unused = wdata_in;

   gpio_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .pad_i  (pad_io),
      .in_o   (in_w)
   );

   for (genvar g = 0; g < WIDTH; g++) begin : g_pad
      assign pad_io[g] = dir_q[g] ? out_q[g] : 1'bz;
   end

   assign set = (in_w & ~prev_q & rise_en_q) | (~in_w & prev_q & fall_en_q);

   always_comb begin
      dir_d     = dir_q;
      out_d     = out_q;
      irq_en_d  = irq_en_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      clr       = '0;
      if (wr_en_in) begin
         case (addr_in)
            ADDR_DIR:     dir_d     = wd;
            ADDR_OUT:     out_d     = wd;
            ADDR_IRQ_EN:  irq_en_d  = wd;
            ADDR_RISE_EN: rise_en_d = wd;
            ADDR_FALL_EN: fall_en_d = wd;
            ADDR_PEND:    clr       = wd;
            ADDR_OUT_TGL: out_d     = out_q ^ wd;
            default:      ;
         endcase
      end
      // A newly detected edge outranks a clear landing in the same cycle.
      pend_d = (pend_q & ~clr) | set;
   end

   always_comb begin
      rd_val = '0;
      case (addr_in)
         ADDR_DIR:     rd_val = dir_q;
         ADDR_OUT:     rd_val = out_q;
         ADDR_IN:      rd_val = in_w;
         ADDR_IRQ_EN:  rd_val = irq_en_q;
         ADDR_RISE_EN: rd_val = rise_en_q;
         ADDR_FALL_EN: rd_val = fall_en_q;
         ADDR_PEND:    rd_val = pend_q;
         default:      rd_val = '0;
      endcase
      rdata_d = rd_en_in ? DATA_W'(zext(MAX_DATA_W'(rd_val), WIDTH)) : rdata_q;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         dir_q     <= '0;
         out_q     <= '0;
         irq_en_q  <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         pend_q    <= '0;
         prev_q    <= '0;
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
      end else begin
         dir_q     <= dir_d;
         out_q     <= out_d;
         irq_en_q  <= irq_en_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         pend_q    <= pend_d;
         prev_q    <= in_w;
         rdata_q   <= rdata_d;
         rvalid_q  <= rd_en_in;
      end
   end

   assign rdata_out  = rdata_q;
   assign rvalid_out = rvalid_q;
   assign irq_out    = |(pend_q & irq_en_q);

endmodule

// File: tb/tb_gpio_port.sv
// Directed bench for gpio_port at default parameters (4 pins, 8-bit bus,
// 2-stage synchroniser).
module tb_gpio_port;

   logic       clk_in;
   logic       rst_in;
   logic [2:0] addr_in;
   logic       wr_en_in;
   logic       rd_en_in;
   logic [7:0] wdata_in;
   logic [7:0] rdata_out;
   logic       rvalid_out;
   logic       irq_out;
   wire  [3:0] pad_w;

   logic [3:0] tb_en;
   logic [3:0] tb_val;

   int n_tests = 0;
   int n_fail  = 0;

   for (genvar i = 0; i < 4; i++) begin : g_drv
      assign pad_w[i] = tb_en[i] ? tb_val[i] : 1'bz;
   end

   gpio_port #(
      .WIDTH       (4),
      .DATA_W      (8),
      .SYNC_STAGES (2)
   ) dut (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .addr_in    (addr_in),
      .wr_en_in   (wr_en_in),
      .rd_en_in   (rd_en_in),
      .wdata_in   (wdata_in),
      .rdata_out  (rdata_out),
      .rvalid_out (rvalid_out),
      .irq_out    (irq_out),
      .pad_io     (pad_w)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL timeout: bench still running at %0t", $time);
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [2:0] a, input logic [7:0] d);
      addr_in  = a;
      wdata_in = d;
      wr_en_in = 1'b1;
      tick();
      wr_en_in = 1'b0;
   endtask

   task automatic do_read(input logic [2:0] a, input logic [7:0] exp, input string tag);
      addr_in  = a;
      rd_en_in = 1'b1;
      tick();
      rd_en_in = 1'b0;
      chk({tag, "_rvalid"}, 32'(rvalid_out), 32'd1);
      chk(tag, 32'(rdata_out), 32'(exp));
   endtask

   initial begin
      rst_in   = 1'b1;
      addr_in  = '0;
      wr_en_in = 1'b0;
      rd_en_in = 1'b0;
      wdata_in = '0;
      tb_en    = 4'hF;
      tb_val   = 4'h0;

      // Reset with a write strobe present: reset must win.
      wr_en_in = 1'b1;
      addr_in  = 3'd0;
      wdata_in = 8'hFF;
      tick();
      wr_en_in = 1'b0;
      tick();
      chk("rst_irq", 32'(irq_out), 32'd0);
      chk("rst_rvalid", 32'(rvalid_out), 32'd0);
      chk("rst_rdata", 32'(rdata_out), 32'd0);
      rst_in = 1'b0;
      chk("rst_pad_z", 32'(pad_w), 32'h0);
      for (int a = 0; a < 8; a++) begin
         do_read(3'(a), 8'h00, $sformatf("rst_rd%0d", a));
      end

      // Drive outputs and read them back through the synchroniser.
      tb_en = 4'h0;
      do_write(3'd0, 8'h0F);
      do_write(3'd1, 8'h0A);
      chk("pad_out", 32'(pad_w), 32'h0000_000A);
      tick();
      tick();
      do_read(3'd2, 8'h0A, "in_readback");

      // Hand pins back to the bench without contention.
      tb_val = 4'hA;
      tb_en  = 4'hF;
      do_write(3'd0, 8'h00);
      tb_val = 4'h0;
      repeat (4) tick();
      do_read(3'd6, 8'h00, "pend_quiet");

      // Rising edge on pin 0.
      do_write(3'd4, 8'h01);
      do_write(3'd3, 8'h01);
      tb_val[0] = 1'b1;
      tick();
      tick();
      chk("rise_irq_early", 32'(irq_out), 32'd0);
      tick();
      chk("rise_irq", 32'(irq_out), 32'd1);
      do_read(3'd6, 8'h01, "rise_pend");
      do_write(3'd6, 8'h01);
      chk("w1c_irq", 32'(irq_out), 32'd0);
      do_read(3'd6, 8'h00, "w1c_pend");

      // Falling edge on pin 2 while masked, then unmask.
      tb_val[2] = 1'b1;
      repeat (4) tick();
      do_write(3'd5, 8'h04);
      do_write(3'd3, 8'h00);
      tb_val[2] = 1'b0;
      repeat (4) tick();
      chk("fall_masked_irq", 32'(irq_out), 32'd0);
      do_read(3'd6, 8'h04, "fall_pend");
      do_write(3'd3, 8'h04);
      chk("unmask_irq", 32'(irq_out), 32'd1);
      do_write(3'd6, 8'h04);
      chk("fall_clr_irq", 32'(irq_out), 32'd0);
      do_write(3'd3, 8'h00);

      // Clear of PEND[0] coinciding with a fresh rise on pin 0.
      tb_val[0] = 1'b0;
      repeat (4) tick();
      tb_val[0] = 1'b1;
      tick();
      tick();
      do_write(3'd6, 8'h01);
      do_read(3'd6, 8'h01, "race_pend");
      do_write(3'd6, 8'hFF);
      do_read(3'd6, 8'h00, "race_cleared");

      // Toggle, upper-bit masking, read-only IN, write-only OUT_TGL.
      do_write(3'd1, 8'h03);
      do_write(3'd7, 8'h05);
      do_read(3'd1, 8'h06, "tgl_out");
      do_read(3'd7, 8'h00, "tgl_rd_zero");
      do_write(3'd3, 8'hF0);
      do_read(3'd3, 8'h00, "upper_bits");
      do_write(3'd2, 8'hFF);
      do_read(3'd2, 8'h01, "in_ro");

      // Read and write of OUT in the same cycle.
      addr_in  = 3'd1;
      wdata_in = 8'h09;
      wr_en_in = 1'b1;
      rd_en_in = 1'b1;
      tick();
      wr_en_in = 1'b0;
      rd_en_in = 1'b0;
      chk("rw_rdata", 32'(rdata_out), 32'h06);
      chk("rw_rvalid", 32'(rvalid_out), 32'd1);
      tick();
      chk("rw_rvalid_drop", 32'(rvalid_out), 32'd0);
      chk("rw_rdata_hold", 32'(rdata_out), 32'h06);
      do_read(3'd1, 8'h09, "rw_after");

      // Build PEND=3, IRQ_EN=3, DIR=F, then reset mid-operation.
      tb_val = 4'h0;
      repeat (4) tick();
      do_write(3'd4, 8'h03);
      tb_val = 4'h3;
      repeat (4) tick();
      do_read(3'd6, 8'h03, "pre_rst_pend");
      do_write(3'd3, 8'h03);
      tb_en = 4'h0;
      do_write(3'd0, 8'h0F);
      chk("pre_rst_irq", 32'(irq_out), 32'd1);
      chk("pre_rst_pad", 32'(pad_w), 32'h9);
      rst_in = 1'b1;
      tb_val = 4'h0;
      tb_en  = 4'hF;
      tick();
      rst_in = 1'b0;
      chk("mid_rst_irq", 32'(irq_out), 32'd0);
      chk("mid_rst_pad_z", 32'(pad_w), 32'h0);
      for (int a = 0; a < 8; a++) begin
         do_read(3'(a), 8'h00, $sformatf("mid_rst_rd%0d", a));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
